riscv_di_i2_issue_ctrl: RTL and testbench

// - Issue2-side controller: drives the i2 end of di_pfb_interface.
// - Inspects the 128b prefetch line at the primary half-word index and decides whether the following 32b instruction can co-issue.
// - Registers the chosen instruction toward the i2 decode stage and returns next_potential_hw_idx/next_hw_idx to the L0 prefetch buffer.
// - Owns the dual-issue enable/cool-down FSM and a pair-issue performance counter.

---
 rtl/riscv_di_pkg.sv | 31 +++
 rtl/di_pfb_interface.sv | 20 ++
 rtl/riscv_di_pair_check.sv | 39 +++
 rtl/riscv_di_i2_issue_ctrl.sv | 133 +++++++++++++
 tb/tb_riscv_di_i2_issue_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_di_pkg.sv
// Shared opcodes, dual-issue FSM states and an R-type field view for the i2 issue controller.
package riscv_di_pkg;

  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] FENCE     = 7'b0001111;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] MULDIV_F7 = 7'b0000001;

  localparam int COOL_W = 3;

  typedef enum logic [1:0] {
    DI_OFF,
    DI_RUN,
    DI_COOL
  } di_state_e;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } rtype_t;

endpackage

// File: rtl/di_pfb_interface.sv
// Link between the L0 prefetch buffer and the i2 issue controller: line + primary index in, allocation + next indices out.
interface di_pfb_interface;
  logic [127:0] line_dat;
  logic [2:0]   pi_hw_idx;
  logic         pi_hw_idx_valid;
  logic         i2_instr_allocate_ok;
  logic         i2_instr_allocated;
  logic [2:0]   next_potential_hw_idx;
  logic [2:0]   next_hw_idx;

  modport i2 (
    input  line_dat, pi_hw_idx, pi_hw_idx_valid,
    output i2_instr_allocate_ok, i2_instr_allocated, next_potential_hw_idx, next_hw_idx
  );

  modport pfb (
    output line_dat, pi_hw_idx, pi_hw_idx_valid,
    input  i2_instr_allocate_ok, i2_instr_allocated, next_potential_hw_idx, next_hw_idx
  );
endinterface

// File: rtl/riscv_di_pair_check.sv
// Combinational pairing check: is i2 a plain ALU op that can run beside pi without a register hazard.
// Zero latency, no state, no backpressure.
module riscv_di_pair_check
  import riscv_di_pkg::*;
(
  input  logic [31:0] pi_i,
  input  logic [31:0] i2_i,
  output logic        pair_ok_o
);

  rtype_t     pi;
  rtype_t     i2;
  logic       pi_ctrl;
  logic       pi_wr;
  logic [4:0] pi_rd;
  logic       i2_is_op;
  logic       i2_alu;
  logic       raw;
  logic       waw;
  logic       unused_fields;

  assign pi = pi_i;
  assign i2 = i2_i;

  always_comb begin
    pi_ctrl  = pi.opcode inside {BRANCH, JAL, JALR, SYSTEM, FENCE};
    pi_wr    = !(pi.opcode inside {STORE, BRANCH});
    // an rd of x0 never creates a dependency, so fold "no write" into rd==0
    pi_rd    = pi_wr ? pi.rd : 5'd0;
    i2_is_op = (i2.opcode == OP);
    i2_alu   = (i2_is_op && (i2.funct7 != MULDIV_F7)) || (i2.opcode == OP_IMM);
    raw      = (pi_rd != 5'd0) && ((pi_rd == i2.rs1) || (i2_is_op && (pi_rd == i2.rs2)));
    waw      = (pi_rd != 5'd0) && (i2.rd == pi_rd);
    pair_ok_o = (pi_i[1:0] == 2'b11) && (i2_i[1:0] == 2'b11) && i2_alu && !pi_ctrl && !raw && !waw;
  end

  assign unused_fields = ^{pi.funct7, pi.rs2, pi.rs1, pi.funct3, i2.funct3};

endmodule

// File: rtl/riscv_di_i2_issue_ctrl.sv
// Issue2 controller: co-issues the 32b instr after the primary, returns next hw indices to the L0 PFB.
// Indices/allocation are combinational; i2 instr is registered one cycle, gated by id_ready_i and flush_i.
module riscv_di_i2_issue_ctrl
  import riscv_di_pkg::*;
#(
  parameter int COOLDOWN_CYCLES = 2,
  parameter bit HWLP_EN         = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  di_pfb_interface.i2 pfb,
  input  logic        di_en_i,
  input  logic        id_ready_i,
  input  logic        flush_i,
  input  logic        hwlp_end_hit_i,
  input  logic [2:0]  hwlp_tgt_hw_i,
  output logic [31:0] i2_instr_o,
  output logic        i2_valid_o,
  output logic [31:0] pair_cnt_o
);

  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN_CYCLES);

  di_state_e         state_q, state_d;
  logic [COOL_W-1:0] cool_cnt_q, cool_cnt_d;
  logic [31:0]       i2_instr_q, i2_instr_d;
  logic              i2_valid_q, i2_valid_d;
  logic [31:0]       pair_cnt_q, pair_cnt_d;

  logic [2:0]  h, h1, h2, h3;
  logic [31:0] pi_word;
  logic [31:0] i2_word;
  logic        pi_comp;
  logic        fits;
  logic        pair_ok;
  logic        hwlp_hit;
  logic        legal;
  logic        allocated;
  logic        fire;
  logic [2:0]  next_pot;

  assign h  = pfb.pi_hw_idx;
  assign h1 = h + 3'd1;
  assign h2 = h + 3'd2;
  assign h3 = h + 3'd3;

  // hw[8] does not exist: a 32b pi at h=7 straddles lines and is never paired
  assign pi_word = {(h == 3'd7) ? 16'h0000 : pfb.line_dat[{h1, 4'b0000} +: 16],
                    pfb.line_dat[{h, 4'b0000} +: 16]};
  assign i2_word = {pfb.line_dat[{h3, 4'b0000} +: 16], pfb.line_dat[{h2, 4'b0000} +: 16]};

  riscv_di_pair_check u_pair_check (
    .pi_i      (pi_word),
    .i2_i      (i2_word),
    .pair_ok_o (pair_ok)
  );

  always_comb begin
    pi_comp   = (pi_word[1:0] != 2'b11);
    fits      = !pi_comp && (h <= 3'd4);
    hwlp_hit  = HWLP_EN && hwlp_end_hit_i;
    legal     = pair_ok && fits && (state_q == DI_RUN) && !hwlp_hit;
    allocated = legal && pfb.pi_hw_idx_valid;
    next_pot  = h + (pi_comp ? 3'd1 : 3'd2) + (allocated ? 3'd2 : 3'd0);
    fire      = allocated && id_ready_i && !flush_i;
  end

  assign pfb.i2_instr_allocate_ok  = legal;
  assign pfb.i2_instr_allocated    = allocated;
  assign pfb.next_potential_hw_idx = next_pot;
  assign pfb.next_hw_idx           = hwlp_hit ? hwlp_tgt_hw_i : next_pot;

  always_comb begin
    state_d    = state_q;
    cool_cnt_d = cool_cnt_q;
    case (state_q)
      DI_OFF: begin
        if (di_en_i) state_d = DI_RUN;
      end
      DI_RUN: begin
        if (!di_en_i) begin
          state_d = DI_OFF;
        end else if (flush_i) begin
          state_d    = DI_COOL;
          cool_cnt_d = COOL_LOAD;
        end
      end
      DI_COOL: begin
        // a fresh redirect restarts the cool-down even if the CSR just dropped
        if (flush_i) begin
          cool_cnt_d = COOL_LOAD;
        end else if (!di_en_i) begin
          state_d    = DI_OFF;
          cool_cnt_d = '0;
        end else if (cool_cnt_q <= COOL_W'(1)) begin
          state_d    = DI_RUN;
          cool_cnt_d = '0;
        end else begin
          cool_cnt_d = cool_cnt_q - COOL_W'(1);
        end
      end
      default: begin
        state_d    = DI_OFF;
        cool_cnt_d = '0;
      end
    endcase

    i2_valid_d = fire;
    i2_instr_d = fire ? i2_word : i2_instr_q;
    pair_cnt_d = (i2_valid_q && (pair_cnt_q != '1)) ? pair_cnt_q + 32'd1 : pair_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DI_OFF;
      cool_cnt_q <= '0;
      i2_instr_q <= '0;
      i2_valid_q <= 1'b0;
      pair_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cool_cnt_q <= cool_cnt_d;
      i2_instr_q <= i2_instr_d;
      i2_valid_q <= i2_valid_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end

  assign i2_instr_o = i2_instr_q;
  assign i2_valid_o = i2_valid_q;
  assign pair_cnt_o = pair_cnt_q;

endmodule

// File: tb/tb_riscv_di_i2_issue_ctrl.sv
// Bench for the i2 issue controller: literal directed cases, then randomized traffic against a behavioural model.
module tb_riscv_di_i2_issue_ctrl;

  localparam int COOLDOWN = 2;
  localparam bit HWLP     = 1'b1;

  localparam logic [127:0] L1 = {64'h0, 32'h002081B3, 32'h00100293};
  localparam logic [127:0] L2 = {64'h0, 32'h002081B3, 32'h00100093};
  localparam logic [127:0] L3 = {8{16'h0293}};
  localparam logic [127:0] L4 = {64'h0, 16'h0505, 16'h81B3, 32'h00100293};

  logic        clk;
  logic        rst_n;
  logic        di_en_i;
  logic        id_ready_i;
  logic        flush_i;
  logic        hwlp_end_hit_i;
  logic [2:0]  hwlp_tgt_hw_i;
  logic [31:0] i2_instr_o;
  logic        i2_valid_o;
  logic [31:0] pair_cnt_o;

  int total = 0;
  int bad   = 0;

  bit          m_on;
  int          m_cool;
  bit          m_vld;
  logic [31:0] m_instr;
  logic [31:0] m_cnt;

  di_pfb_interface pfb_if ();

  riscv_di_i2_issue_ctrl #(
    .COOLDOWN_CYCLES (COOLDOWN),
    .HWLP_EN         (HWLP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pfb            (pfb_if),
    .di_en_i        (di_en_i),
    .id_ready_i     (id_ready_i),
    .flush_i        (flush_i),
    .hwlp_end_hit_i (hwlp_end_hit_i),
    .hwlp_tgt_hw_i  (hwlp_tgt_hw_i),
    .i2_instr_o     (i2_instr_o),
    .i2_valid_o     (i2_valid_o),
    .pair_cnt_o     (pair_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] line, input logic [2:0] h, input bit vld,
                       input bit fl, input bit hl, input logic [2:0] tgt);
    pfb_if.line_dat        = line;
    pfb_if.pi_hw_idx       = h;
    pfb_if.pi_hw_idx_valid = vld;
    flush_i                = fl;
    hwlp_end_hit_i         = hl;
    hwlp_tgt_hw_i          = tgt;
  endtask

  function automatic logic [31:0] rnd_instr(input bit for_i2);
    logic [6:0] op;
    logic [6:0] f7;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    rd  = 5'($urandom_range(0, 3));
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    f3  = 3'($urandom_range(0, 7));
    f7  = ($urandom_range(0, 3) == 0) ? 7'b0000001 : 7'b0000000;
    if (for_i2) begin
      case ($urandom_range(0, 4))
        0, 1:    op = 7'h33;
        2, 3:    op = 7'h13;
        default: op = 7'h37;
      endcase
    end else begin
      case ($urandom_range(0, 10))
        0, 1:    op = 7'h33;
        2, 3:    op = 7'h13;
        4:       op = 7'h03;
        5:       op = 7'h23;
        6:       op = 7'h63;
        7:       op = 7'h6F;
        8:       op = 7'h67;
        9:       op = 7'h0F;
        default: op = 7'h73;
      endcase
    end
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  // Reference model: pairing rules evaluated on raw halfwords, checked every cycle.
  always @(negedge clk) begin : compare
    logic [15:0] hw [8];
    logic [31:0] pi, cand;
    logic [4:0]  prd;
    bit          comp, op_ok, ctrl, raw, waw, ok, alloc, fire;
    int          h, np, nh;
    if (!rst_n) begin
      m_on = 0; m_cool = 0; m_vld = 0; m_instr = '0; m_cnt = '0;
    end
    h = int'(pfb_if.pi_hw_idx);
    for (int k = 0; k < 8; k++) hw[k] = pfb_if.line_dat[16*k +: 16];
    pi = {16'h0, hw[h]};
    if (h < 7) pi[31:16] = hw[h+1];
    cand = 32'h0;
    if (h <= 4) cand = {hw[h+3], hw[h+2]};
    comp  = (pi[1:0] != 2'b11);
    op_ok = (cand[6:0] == 7'h33 && cand[31:25] != 7'h01) || cand[6:0] == 7'h13;
    ctrl  = pi[6:0] inside {7'h63, 7'h6F, 7'h67, 7'h73, 7'h0F};
    prd   = (pi[6:0] == 7'h23 || pi[6:0] == 7'h63) ? 5'd0 : pi[11:7];
    raw   = prd != 0 && (prd == cand[19:15] || (cand[6:0] == 7'h33 && prd == cand[24:20]));
    waw   = prd != 0 && cand[11:7] == prd;
    ok    = m_on && m_cool == 0 && !(HWLP && hwlp_end_hit_i) && !comp && h <= 4 &&
            cand[1:0] == 2'b11 && op_ok && !ctrl && !raw && !waw;
    alloc = ok && pfb_if.pi_hw_idx_valid;
    np    = (h + (comp ? 1 : 2) + (alloc ? 2 : 0)) % 8;
    nh    = (HWLP && hwlp_end_hit_i) ? int'(hwlp_tgt_hw_i) : np;

    chk("model_ok",        32'(pfb_if.i2_instr_allocate_ok), 32'(ok));
    chk("model_alloc",     32'(pfb_if.i2_instr_allocated), 32'(alloc));
    chk("model_next_pot",  32'(pfb_if.next_potential_hw_idx), 32'(np));
    chk("model_next_hw",   32'(pfb_if.next_hw_idx), 32'(nh));
    chk("model_i2_valid",  32'(i2_valid_o), 32'(m_vld));
    chk("model_i2_instr",  i2_instr_o, m_instr);
    chk("model_pair_cnt",  pair_cnt_o, m_cnt);

    if (rst_n) begin
      if (m_vld && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      fire  = alloc && id_ready_i && !flush_i;
      m_vld = fire;
      if (fire) m_instr = cand;
      if (!m_on) begin
        m_on = di_en_i; m_cool = 0;
      end else if (m_cool == 0) begin
        if (!di_en_i) m_on = 0;
        else if (flush_i) m_cool = COOLDOWN;
      end else if (flush_i) begin
        m_cool = COOLDOWN;
      end else if (!di_en_i) begin
        m_on = 0; m_cool = 0;
      end else begin
        m_cool = m_cool - 1;
      end
    end
  end

  initial begin
    logic [127:0] line;
    logic [31:0]  pi, i2;
    int           h;
    rst_n = 1'b0; di_en_i = 1'b0; id_ready_i = 1'b0;
    drive('0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0);
    repeat (3) @(posedge clk);

    // A: out of reset the FSM is OFF, so even a legal line cannot pair
    step(); rst_n = 1'b1; di_en_i = 1'b1; id_ready_i = 1'b1;
    drive(L1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0);
    #2;
    chk("rst_ok", 32'(pfb_if.i2_instr_allocate_ok), 32'd0);
    chk("rst_valid", 32'(i2_valid_o), 32'd0);
    chk("rst_instr", i2_instr_o, 32'd0);
    chk("rst_cnt", pair_cnt_o, 32'd0);
    // B: ADDI x5 + ADD x3,x1,x2 pairs
    step(); #2;
    chk("pair_ok", 32'(pfb_if.i2_instr_allocate_ok), 32'd1);
    chk("pair_alloc", 32'(pfb_if.i2_instr_allocated), 32'd1);
    chk("pair_next_hw", 32'(pfb_if.next_hw_idx), 32'd4);
    // C: RAW on x1 blocks pairing; previous pair shows up
    step(); drive(L2, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0); #2;
    chk("pair_valid", 32'(i2_valid_o), 32'd1);
    chk("pair_instr", i2_instr_o, 32'h002081B3);
    chk("raw_ok", 32'(pfb_if.i2_instr_allocate_ok), 32'd0);
    chk("raw_next_hw", 32'(pfb_if.next_hw_idx), 32'd2);
    // D: 32b pi at h=5 leaves no room for i2
    step(); drive(L3, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0); #2;
    chk("raw_no_valid", 32'(i2_valid_o), 32'd0);
    chk("cnt_one", pair_cnt_o, 32'd1);
    chk("h5_ok", 32'(pfb_if.i2_instr_allocate_ok), 32'd0);
    chk("h5_next_hw", 32'(pfb_if.next_hw_idx), 32'd7);
    // E: 32b pi at h=6 wraps to the next line
    step(); drive(L3, 3'd6, 1'b1, 1'b0, 1'b0, 3'd0); #2;
    chk("h6_next_pot", 32'(pfb_if.next_potential_hw_idx), 32'd0);
    // F: compressed pi at h=3
    step(); drive(L4, 3'd3, 1'b1, 1'b0, 1'b0, 3'd0); #2;
    chk("c_ok", 32'(pfb_if.i2_instr_allocate_ok), 32'd0);
    chk("c_next_hw", 32'(pfb_if.next_hw_idx), 32'd4);
    // G: flush coincident with a legal pair
    step(); drive(L1, 3'd0, 1'b1, 1'b1, 1'b0, 3'd0); #2;
    chk("flush_alloc", 32'(pfb_if.i2_instr_allocated), 32'd1);
    // H, I: two cool-down cycles
    step(); drive(L1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0); #2;
    chk("flush_no_valid", 32'(i2_valid_o), 32'd0);
    chk("cool1_ok", 32'(pfb_if.i2_instr_allocate_ok), 32'd0);
    step(); #2;
    chk("cool2_ok", 32'(pfb_if.i2_instr_allocate_ok), 32'd0);
    // J: dual issue back
    step(); #2;
    chk("rerun_ok", 32'(pfb_if.i2_instr_allocate_ok), 32'd1);
    chk("flush_cnt_kept", pair_cnt_o, 32'd1);
    // K: hwloop end redirects to target
    step(); drive(L1, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1); #2;
    chk("rerun_valid", 32'(i2_valid_o), 32'd1);
    chk("hwlp_ok", 32'(pfb_if.i2_instr_allocate_ok), 32'd0);
    chk("hwlp_next_hw", 32'(pfb_if.next_hw_idx), 32'd1);
    chk("hwlp_next_pot", 32'(pfb_if.next_potential_hw_idx), 32'd2);
    // L, M: pair in flight, then async reset
    step(); drive(L1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0); #2;
    chk("cnt_two", pair_cnt_o, 32'd2);
    step(); #2;
    chk("inflight_valid", 32'(i2_valid_o), 32'd1);
    rst_n = 1'b0; #1;
    chk("arst_valid", 32'(i2_valid_o), 32'd0);
    chk("arst_cnt", pair_cnt_o, 32'd0);
    chk("arst_ok", 32'(pfb_if.i2_instr_allocate_ok), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      step();
      rst_n = 1'b1;
      line = {$urandom, $urandom, $urandom, $urandom};
      h  = $urandom_range(0, 7);
      pi = rnd_instr(1'b0);
      i2 = rnd_instr(1'b1);
      if ($urandom_range(0, 4) == 0) pi[1:0] = 2'($urandom_range(0, 2));
      line[16*h +: 16] = pi[15:0];
      if (h < 7) line[16*(h+1) +: 16] = pi[31:16];
      if (h < 5) begin
        line[16*(h+2) +: 16] = i2[15:0];
        line[16*(h+3) +: 16] = i2[31:16];
      end
      di_en_i    = ($urandom_range(0, 15) != 0);
      id_ready_i = ($urandom_range(0, 3) != 0);
      drive(line, 3'(h), $urandom_range(0, 7) != 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 15) == 0, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 299) == 0) begin
        #2;
        rst_n = 1'b0;
      end
    end

    step();
    rst_n = 1'b1;
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
